// File: rtl/dll_mag_seq.sv
// Early/late I^2+Q^2 sequencer feeding a shared sqrt unit through one multiplier.
// Optional watchdog enabled by defining DLL_MAG_TIMEOUT_EN (adds the timeout_err port).
module dll_mag_seq #(
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned PWR_WIDTH      = 2 * ACC_WIDTH,
  parameter int unsigned MAG_WIDTH      = ACC_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] i_early,
  input  logic signed [ACC_WIDTH-1:0] q_early,
  input  logic signed [ACC_WIDTH-1:0] i_late,
  input  logic signed [ACC_WIDTH-1:0] q_late,
  output logic                        sqrt_input_ready,
  output logic [PWR_WIDTH-1:0]        sqrt_in,
  input  logic                        sqrt_in_use,
  input  logic                        sqrt_output_ready,
  input  logic [MAG_WIDTH-1:0]        sqrt_out,
  output logic [MAG_WIDTH-1:0]        mag_early,
  output logic [MAG_WIDTH-1:0]        mag_late,
  output logic                        done,
`ifdef DLL_MAG_TIMEOUT_EN
  output logic                        timeout_err,
`endif
  output logic                        busy
);

  localparam int unsigned PROD_WIDTH = 2 * ACC_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SQ_IE,
    S_SQ_QE,
    S_SQ_IL,
    S_SQ_QL,
    S_REQ_E,
    S_WAIT_E,
    S_REQ_L,
    S_WAIT_L,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [ACC_WIDTH-1:0] ie_q, qe_q, il_q, ql_q;
  logic signed [ACC_WIDTH-1:0] ie_d, qe_d, il_d, ql_d;
  logic [PWR_WIDTH-1:0]        pwr_e_q, pwr_l_q, pwr_e_d, pwr_l_d;
  logic [MAG_WIDTH-1:0]        hold_e_q, hold_l_q, hold_e_d, hold_l_d;

  logic                        sqrt_input_ready_d;
  logic [PWR_WIDTH-1:0]        sqrt_in_d;
  logic [MAG_WIDTH-1:0]        mag_early_d, mag_late_d;
  logic                        done_d;
  logic                        busy_d;

  logic                        sqrt_accept;
  logic                        tmo_hit;
  logic [ACC_WIDTH-1:0]        sq_op;
  logic [PROD_WIDTH-1:0]       sq_ext;
  logic [PROD_WIDTH-1:0]       sq_prod;

  // Handshake completes on the cycle the request is up and the sqrt unit is free.
  assign sqrt_accept = sqrt_input_ready & ~sqrt_in_use;

  // Shared squarer: the sign-extended operand squared modulo 2^PROD_WIDTH is the exact square.
  always_comb begin
    sq_op = '0;
    case (state_q)
      S_SQ_IE: sq_op = ie_q;
      S_SQ_QE: sq_op = qe_q;
      S_SQ_IL: sq_op = il_q;
      S_SQ_QL: sq_op = ql_q;
      default: sq_op = '0;
    endcase
  end

  assign sq_ext  = {{ACC_WIDTH{sq_op[ACC_WIDTH-1]}}, sq_op};
  assign sq_prod = sq_ext * sq_ext;

`ifdef DLL_MAG_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_err_d;
  logic                 in_req_wait;

  assign in_req_wait = (state_q == S_REQ_E) || (state_q == S_WAIT_E) ||
                       (state_q == S_REQ_L) || (state_q == S_WAIT_L);
  assign tmo_hit     = in_req_wait && (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on entry to each request phase and runs through its wait.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err;
    if ((state_q == S_SQ_QL) || ((state_q == S_WAIT_E) && sqrt_output_ready)) begin
      tmo_cnt_d = '0;
    end else if (in_req_wait) begin
      tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
    end
    if ((state_q == S_IDLE) && start) begin
      timeout_err_d = 1'b0;
    end
    if (tmo_hit) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_err <= timeout_err_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SQ_IE;
      S_SQ_IE:  state_d = S_SQ_QE;
      S_SQ_QE:  state_d = S_SQ_IL;
      S_SQ_IL:  state_d = S_SQ_QL;
      S_SQ_QL:  state_d = S_REQ_E;
      S_REQ_E:  if (sqrt_accept) state_d = S_WAIT_E;
      S_WAIT_E: if (sqrt_output_ready) state_d = S_REQ_L;
      S_REQ_L:  if (sqrt_accept) state_d = S_WAIT_L;
      S_WAIT_L: if (sqrt_output_ready) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

  // Output and datapath next values; every output is registered below.
  always_comb begin
    ie_d               = ie_q;
    qe_d               = qe_q;
    il_d               = il_q;
    ql_d               = ql_q;
    pwr_e_d            = pwr_e_q;
    pwr_l_d            = pwr_l_q;
    hold_e_d           = hold_e_q;
    hold_l_d           = hold_l_q;
    sqrt_input_ready_d = sqrt_input_ready;
    sqrt_in_d          = sqrt_in;
    mag_early_d        = mag_early;
    mag_late_d         = mag_late;
    done_d             = 1'b0;
    busy_d             = busy;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ie_d   = i_early;
          qe_d   = q_early;
          il_d   = i_late;
          ql_d   = q_late;
          busy_d = 1'b1;
        end
      end
      S_SQ_IE: pwr_e_d = PWR_WIDTH'(sq_prod);
      S_SQ_QE: pwr_e_d = pwr_e_q + PWR_WIDTH'(sq_prod);
      S_SQ_IL: pwr_l_d = PWR_WIDTH'(sq_prod);
      S_SQ_QL: begin
        pwr_l_d            = pwr_l_q + PWR_WIDTH'(sq_prod);
        sqrt_input_ready_d = 1'b1;
        sqrt_in_d          = pwr_e_q;
      end
      S_REQ_E, S_REQ_L: begin
        if (sqrt_accept) begin
          sqrt_input_ready_d = 1'b0;
        end
      end
      S_WAIT_E: begin
        if (sqrt_output_ready) begin
          hold_e_d           = sqrt_out;
          sqrt_input_ready_d = 1'b1;
          sqrt_in_d          = pwr_l_q;
        end
      end
      S_WAIT_L: begin
        if (sqrt_output_ready) begin
          hold_l_d = sqrt_out;
        end
      end
      S_DONE: begin
        mag_early_d = hold_e_q;
        mag_late_d  = hold_l_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase

    // Watchdog abort reports zero magnitudes with a done pulse.
    if (tmo_hit) begin
      sqrt_input_ready_d = 1'b0;
      mag_early_d        = '0;
      mag_late_d         = '0;
      done_d             = 1'b1;
      busy_d             = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q             <= '0;
      qe_q             <= '0;
      il_q             <= '0;
      ql_q             <= '0;
      pwr_e_q          <= '0;
      pwr_l_q          <= '0;
      hold_e_q         <= '0;
      hold_l_q         <= '0;
      sqrt_input_ready <= 1'b0;
      sqrt_in          <= '0;
      mag_early        <= '0;
      mag_late         <= '0;
      done             <= 1'b0;
      busy             <= 1'b0;
    end else begin
      ie_q             <= ie_d;
      qe_q             <= qe_d;
      il_q             <= il_d;
      ql_q             <= ql_d;
      pwr_e_q          <= pwr_e_d;
      pwr_l_q          <= pwr_l_d;
      hold_e_q         <= hold_e_d;
      hold_l_q         <= hold_l_d;
      sqrt_input_ready <= sqrt_input_ready_d;
      sqrt_in          <= sqrt_in_d;
      mag_early        <= mag_early_d;
      mag_late         <= mag_late_d;
      done             <= done_d;
      busy             <= busy_d;
    end
  end

endmodule

// File: tb/tb_dll_mag_seq.sv
// Scoreboard bench for dll_mag_seq: exact-root sqrt model with programmable latency and back-pressure.
module tb_dll_mag_seq;
  localparam int unsigned ACC_WIDTH      = 16;
  localparam int unsigned PWR_WIDTH      = 2 * ACC_WIDTH;
  localparam int unsigned MAG_WIDTH      = ACC_WIDTH;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic signed [ACC_WIDTH-1:0] i_early, q_early, i_late, q_late;
  logic                        sqrt_input_ready;
  logic [PWR_WIDTH-1:0]        sqrt_in;
  logic                        sqrt_in_use = 1'b0;
  logic                        sqrt_output_ready = 1'b0;
  logic [MAG_WIDTH-1:0]        sqrt_out = '0;
  logic [MAG_WIDTH-1:0]        mag_early, mag_late;
  logic                        done;
  logic                        busy;
`ifdef DLL_MAG_TIMEOUT_EN
  logic                        timeout_err;
`endif

  dll_mag_seq #(
    .ACC_WIDTH      (ACC_WIDTH),
    .PWR_WIDTH      (PWR_WIDTH),
    .MAG_WIDTH      (MAG_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .i_early           (i_early),
    .q_early           (q_early),
    .i_late            (i_late),
    .q_late            (q_late),
    .sqrt_input_ready  (sqrt_input_ready),
    .sqrt_in           (sqrt_in),
    .sqrt_in_use       (sqrt_in_use),
    .sqrt_output_ready (sqrt_output_ready),
    .sqrt_out          (sqrt_out),
    .mag_early         (mag_early),
    .mag_late          (mag_late),
    .done              (done),
`ifdef DLL_MAG_TIMEOUT_EN
    .timeout_err       (timeout_err),
`endif
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned mag_e;
    longint unsigned mag_l;
    bit              tmo;
  } exp_t;

  exp_t            exp_q[$];
  longint unsigned pwr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // sqrt model and bookkeeping
  int                   lat = 20;
  int                   force_bp = -1;
  bit                   bp_check = 1'b0;
  int                   bp_expect = 0;
  bit                   suppress_result = 1'b0;
  bit                   pending = 1'b0;
  int                   lat_left = 0;
  logic [MAG_WIDTH-1:0] pend_val = '0;
  int                   bp_left = 0;
  int                   hold_cnt = 0;
  logic                 prev_ready = 1'b0;
  logic [PWR_WIDTH-1:0] req_val = '0;
  int                   req_cycle = 0;
  int                   acc_count = 0;
  int                   done_seen = 0;
  int                   done_cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 16; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  function automatic longint unsigned power(input int i, input int q);
    return longint'(i) * longint'(i) + longint'(q) * longint'(q);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // External sqrt unit: decides in_use for the coming edge, then books the acceptance.
  always @(negedge clk) begin : sqrt_model
    sqrt_output_ready = 1'b0;
    if (pending) begin
      if (lat_left <= 1) begin
        sqrt_output_ready = 1'b1;
        sqrt_out          = pend_val;
        pending           = 1'b0;
      end else begin
        lat_left--;
      end
    end
    if (sqrt_input_ready && !prev_ready) begin
      bp_left   = (force_bp >= 0) ? force_bp : int'($urandom_range(0, 3));
      force_bp  = -1;
      hold_cnt  = 0;
      req_val   = sqrt_in;
      req_cycle = cyc;
    end
    if (sqrt_input_ready && bp_left > 0) begin
      sqrt_in_use = 1'b1;
      bp_left--;
      hold_cnt++;
      chk("sqrt_in_stable", 64'(sqrt_in), 64'(req_val));
    end else begin
      sqrt_in_use = 1'b0;
    end
    if (sqrt_input_ready && !sqrt_in_use) begin
      acc_count++;
      if (pwr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_accept: got sqrt_in=%0d accepted, required no request (t=%0t)", sqrt_in, $time);
      end else begin
        chk("sqrt_in", 64'(sqrt_in), pwr_q.pop_front());
      end
      if (bp_check) begin
        chk("bp_hold_cycles", 64'(hold_cnt), 64'(bp_expect));
        bp_check = 1'b0;
      end
      if (!suppress_result) begin
        pending  = 1'b1;
        lat_left = lat;
        pend_val = MAG_WIDTH'(isqrt(64'(sqrt_in)));
      end
    end
    prev_ready = sqrt_input_ready;
  end

  // Result monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      done_seen++;
      done_cycle = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, required 0 with nothing outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("mag_early", 64'(mag_early), e.mag_e);
        chk("mag_late", 64'(mag_late), e.mag_l);
        chk("busy_at_done", 64'(busy), 64'd0);
`ifdef DLL_MAG_TIMEOUT_EN
        chk("timeout_err", 64'(timeout_err), 64'(e.tmo));
`endif
      end
    end
  end

  task automatic issue(input int ie, input int qe, input int il, input int ql, input bit tmo);
    exp_t e;
    @(posedge clk);
    #1;
    i_early = ACC_WIDTH'(ie);
    q_early = ACC_WIDTH'(qe);
    i_late  = ACC_WIDTH'(il);
    q_late  = ACC_WIDTH'(ql);
    start   = 1'b1;
    pwr_q.push_back(power(ie, qe));
    if (!tmo) pwr_q.push_back(power(il, ql));
    e.mag_e = tmo ? 64'd0 : isqrt(power(ie, qe));
    e.mag_l = tmo ? 64'd0 : isqrt(power(il, ql));
    e.tmo   = tmo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int target);
    int c = 0;
    while (done_seen < target && c < 500) begin
      @(posedge clk);
      c++;
    end
    chk("done_within_bound", 64'(done_seen >= target), 64'd1);
  endtask

  task automatic wait_accept(input int prev);
    int c = 0;
    while (acc_count <= prev && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("accept_within_bound", 64'(acc_count > prev), 64'd1);
  endtask

  task automatic run_op(input int ie, input int qe, input int il, input int ql);
    int tgt;
    tgt = done_seen + 1;
    issue(ie, qe, il, ql, 1'b0);
    wait_done(tgt);
  endtask

  function automatic int rnd_acc();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int tgt;
    int a;
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    i_early = '0;
    q_early = '0;
    i_late  = '0;
    q_late  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sqrt_input_ready", 64'(sqrt_input_ready), 64'd0);
    chk("rst_sqrt_in", 64'(sqrt_in), 64'd0);
    chk("rst_mag_early", 64'(mag_early), 64'd0);
    chk("rst_mag_late", 64'(mag_late), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // nominal, extremes, zero
    lat = 20;
    run_op(3, 4, 5, 12);
    run_op(-32768, -32768, -32768, -32768);
    run_op(0, 0, 0, 0);

    // sustained back-pressure on the early request
    force_bp  = 10;
    bp_check  = 1'b1;
    bp_expect = 10;
    run_op(100, -200, -300, 400);
    chk("bp_check_consumed", 64'(bp_check), 64'd0);

    // start while busy must be ignored
    tgt = done_seen + 1;
    a   = acc_count;
    issue(7, -24, -9, 40, 1'b0);
    wait_accept(a);
    repeat (3) @(posedge clk);
    #1;
    i_early = 16'sd1234;
    q_early = -16'sd4321;
    i_late  = 16'sd999;
    q_late  = -16'sd777;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(tgt);

    // reset while waiting for the early root; its late result must be ignored
    d0 = done_seen;
    a  = acc_count;
    issue(11, 60, -13, 84, 1'b0);
    wait_accept(a);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    pwr_q.delete();
    repeat (lat + 10) @(posedge clk);
    @(negedge clk);
    chk("abort_mag_early", 64'(mag_early), 64'd0);
    chk("abort_mag_late", 64'(mag_late), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sqrt_input_ready", 64'(sqrt_input_ready), 64'd0);
    chk("abort_sqrt_in", 64'(sqrt_in), 64'd0);
    chk("abort_no_done", 64'(done_seen), 64'(d0));
    run_op(3, 4, 5, 12);

    // randomized operations with random sqrt latency
    for (int n = 0; n < 20; n++) begin
      lat = int'($urandom_range(1, 25));
      run_op(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc());
    end

`ifdef DLL_MAG_TIMEOUT_EN
    // sqrt unit never answers: watchdog must end the operation
    suppress_result = 1'b1;
    tgt = done_seen + 1;
    issue(3, 4, 5, 12, 1'b1);
    wait_done(tgt);
    chk("timeout_latency_ok", 64'((done_cycle - req_cycle) <= int'(TIMEOUT_CYCLES)), 64'd1);
    suppress_result = 1'b0;
    pending         = 1'b0;
    pwr_q.delete();
    run_op(-5, 12, 8, -15);
`endif

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("pwr_q_drained", 64'(pwr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
